// File: rtl/alu_pipe_core.sv
// alu_pipe_core: two-stage register-file ALU core with forwarding and an iterative restoring divider
module alu_pipe_core #(
  parameter int DATA_W = 4,
  parameter int NREGS = 8,
  localparam int RA_W = $clog2(NREGS),
  localparam int INST_W = 7 + 3 * RA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_W-1:0]     in_inst,
  output logic                  out_valid,
  output logic [2*DATA_W-1:0]   out_result,
  output logic                  out_zero,
  output logic                  out_wr
);
  localparam int W2 = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W + 1);
  logic [2:0] op;
  logic [3:0] func;
  logic [RA_W-1:0] rs1, rs2, rd;
  logic s1_v_q, s1_v_d, s1_wr_q, s1_wr_d;
  logic [3:0] s1_func_q, s1_func_d;
  logic [RA_W-1:0] s1_rd_q, s1_rd_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dr_q, dr_d, dq_q, dq_d;
  logic out_valid_q, out_valid_d, out_zero_q, out_zero_d, out_wr_q, out_wr_d;
  logic [W2-1:0] out_result_q, out_result_d;
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];
  logic busy, ex_fire, accept, wr_en, ge;
  logic [W2-1:0] res;
  logic [DATA_W-1:0] wdata, opa, opb, sub;
  logic [DATA_W:0] t;
  assign op = in_inst[2:0];
  assign func = in_inst[6:3];
  assign rs2 = in_inst[7 +: RA_W];
  assign rs1 = in_inst[7 + RA_W +: RA_W];
  assign rd = in_inst[7 + 2 * RA_W +: RA_W];
  assign busy = s1_v_q && (s1_func_q == 4'd9 || s1_func_q == 4'd10) && cnt_q != CW'(DATA_W);
  assign ex_fire = s1_v_q && !busy;
  assign in_ready = !rst && !busy;
  assign accept = in_valid && in_ready;
  assign wr_en = ex_fire && s1_wr_q;
  assign wdata = res[DATA_W-1:0];
  assign opa = (wr_en && s1_rd_q == rs1) ? wdata : rf_q[rs1];
  assign opb = (wr_en && s1_rd_q == rs2) ? wdata : rf_q[rs2];
  // one restoring step: shift the next dividend bit into the partial remainder
  assign t = {dr_q, dq_q[DATA_W-1]};
  assign ge = t >= {1'b0, s1_b_q};
  assign sub = t[DATA_W-1:0] - s1_b_q;
  assign out_valid = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero = out_zero_q;
  assign out_wr = out_wr_q;
  always_comb begin
    res = '0;
    case (s1_func_q)
      4'd0: res[DATA_W-1:0] = s1_a_q & s1_b_q;
      4'd1: res[DATA_W-1:0] = s1_a_q | s1_b_q;
      4'd2: res[DATA_W-1:0] = s1_a_q ^ s1_b_q;
      4'd3: res[DATA_W-1:0] = ~(s1_a_q & s1_b_q);
      4'd4: res[DATA_W-1:0] = ~(s1_a_q | s1_b_q);
      4'd5: res[DATA_W-1:0] = ~(s1_a_q ^ s1_b_q);
      4'd6: res[DATA_W:0] = {1'b0, s1_a_q} + {1'b0, s1_b_q};
      4'd7: res[DATA_W:0] = {1'b0, s1_a_q} - {1'b0, s1_b_q};
      4'd8: res = {{DATA_W{1'b0}}, s1_a_q} * {{DATA_W{1'b0}}, s1_b_q};
      4'd9: res = {dr_q, dq_q};
      4'd10: res = {dq_q, dr_q};
      4'd11: res[DATA_W-1:0] = DATA_W'(s1_a_q < s1_b_q);
      4'd12: res[DATA_W-1:0] = DATA_W'(s1_a_q > s1_b_q);
      4'd13: res[DATA_W-1:0] = DATA_W'(s1_a_q == s1_b_q);
      4'd14: res[DATA_W-1:0] = s1_a_q << s1_b_q;
      default: res[DATA_W-1:0] = s1_a_q >> s1_b_q;
    endcase
  end
  always_comb begin
    s1_v_d = ex_fire ? 1'b0 : s1_v_q;
    s1_wr_d = s1_wr_q;
    s1_func_d = s1_func_q;
    s1_rd_d = s1_rd_q;
    s1_a_d = s1_a_q;
    s1_b_d = s1_b_q;
    cnt_d = busy ? cnt_q + 1'b1 : cnt_q;
    dr_d = busy ? (ge ? sub : t[DATA_W-1:0]) : dr_q;
    dq_d = busy ? {dq_q[DATA_W-2:0], ge} : dq_q;
    if (accept) begin
      s1_v_d = op[2:1] == 2'b01;
      s1_wr_d = op[0];
      s1_func_d = func;
      s1_rd_d = rd;
      s1_a_d = opa;
      s1_b_d = opb;
      cnt_d = '0;
      dr_d = '0;
      dq_d = opa;
    end
    out_valid_d = ex_fire;
    out_result_d = ex_fire ? res : out_result_q;
    out_zero_d = ex_fire ? res == '0 : out_zero_q;
    out_wr_d = ex_fire ? s1_wr_q : out_wr_q;
    rf_d = rf_q;
    if (wr_en) rf_d[s1_rd_q] = wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q <= 1'b0;
      s1_wr_q <= 1'b0;
      s1_func_q <= '0;
      s1_rd_q <= '0;
      s1_a_q <= '0;
      s1_b_q <= '0;
      cnt_q <= '0;
      dr_q <= '0;
      dq_q <= '0;
      out_valid_q <= 1'b0;
      out_result_q <= '0;
      out_zero_q <= 1'b0;
      out_wr_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= DATA_W'(i);
    end else begin
      s1_v_q <= s1_v_d;
      s1_wr_q <= s1_wr_d;
      s1_func_q <= s1_func_d;
      s1_rd_q <= s1_rd_d;
      s1_a_q <= s1_a_d;
      s1_b_q <= s1_b_d;
      cnt_q <= cnt_d;
      dr_q <= dr_d;
      dq_q <= dq_d;
      out_valid_q <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q <= out_zero_d;
      out_wr_q <= out_wr_d;
      rf_q <= rf_d;
    end
  end
endmodule

// File: tb/tb_alu_pipe_core.sv
// tb_alu_pipe_core: directed table, latency/abort sequences and random traffic against a reference model
module tb_alu_pipe_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_inst = '0;
  logic out_valid;
  logic [7:0] out_result;
  logic out_zero;
  logic out_wr;
  alu_pipe_core #(.DATA_W(4), .NREGS(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_result(out_result), .out_zero(out_zero), .out_wr(out_wr)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] op;
    logic [3:0] f;
    int rd, rs1, rs2;
    logic [7:0] eres;
  } vec_t;
  typedef struct {
    logic [7:0] r;
    logic w;
  } exp_t;
  localparam int NT = 21;
  vec_t tbl [NT];
  exp_t expq [$];
  int mreg [8];
  int n_cmp = 0;
  int n_fail = 0;
  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask
  function automatic logic [7:0] ref_alu(input int f, input int a, input int b);
    case (f)
      0: return 8'(a & b);
      1: return 8'(a | b);
      2: return 8'(a ^ b);
      3: return 8'(~(a & b) & 15);
      4: return 8'(~(a | b) & 15);
      5: return 8'(~(a ^ b) & 15);
      6: return 8'(a + b);
      7: return 8'((a < b ? 16 : 0) + ((a - b) & 15));
      8: return 8'(a * b);
      9: return b == 0 ? 8'((a << 4) | 15) : 8'(((a % b) << 4) | (a / b));
      10: return b == 0 ? 8'(240 | a) : 8'(((a / b) << 4) | (a % b));
      11: return 8'(a < b);
      12: return 8'(a > b);
      13: return 8'(a == b);
      14: return b >= 4 ? 8'd0 : 8'((a << b) & 15);
      default: return b >= 4 ? 8'd0 : 8'(a >> b);
    endcase
  endfunction
  // mode 0: expect model value, 1: expect table value, 2: untracked (will be aborted)
  task automatic issue(input logic [2:0] op, input logic [3:0] f, input int rd, input int rs1,
                       input int rs2, input int mode, input logic [7:0] tres);
    int n = 0;
    logic [7:0] r;
    r = ref_alu(int'(f), mreg[rs1], mreg[rs2]);
    if (mode != 2 && op[2:1] == 2'b01) begin
      expq.push_back('{(mode == 1) ? tres : r, op[0]});
      if (op[0]) mreg[rd] = r & 15;
    end
    in_valid = 1'b1;
    in_inst = {3'(rd), 3'(rs1), 3'(rs2), f, op};
    while (!in_ready && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready %b required 1", in_ready);
    end else @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) check("spurious_out_valid", 16'(out_valid), 16'd0);
      else begin
        exp_t e;
        e = expq.pop_front();
        check("out_result", 16'(out_result), 16'(e.r));
        check("out_zero", 16'(out_zero), 16'(e.r == 8'd0));
        check("out_wr", 16'(out_wr), 16'(e.w));
      end
    end
  end
  task automatic latency(input logic [3:0] f, input int exp_lat, input int exp_low);
    int lat = 0;
    int low = 0;
    issue(3'b010, f, 0, 7, 2, 0, 8'd0);
    do begin
      @(negedge clk);
      lat++;
      if (!in_ready) low++;
    end while (!out_valid && lat < 30);
    check("latency", 16'(lat), 16'(exp_lat));
    check("ready_low_cycles", 16'(low), 16'(exp_low));
  endtask
  initial begin
    tbl = '{
      '{3'b010, 4'd14, 0, 1, 2, 8'h04}, '{3'b010, 4'd15, 0, 7, 5, 8'h00},
      '{3'b011, 4'd6, 1, 7, 7, 8'h0E}, '{3'b010, 4'd6, 0, 1, 0, 8'h0E},
      '{3'b011, 4'd7, 3, 2, 5, 8'h1D}, '{3'b011, 4'd6, 4, 3, 3, 8'h1A},
      '{3'b010, 4'd6, 0, 4, 0, 8'h0A}, '{3'b011, 4'd8, 6, 7, 6, 8'h2A},
      '{3'b010, 4'd6, 0, 6, 0, 8'h0A}, '{3'b010, 4'd13, 5, 5, 5, 8'h01},
      '{3'b010, 4'd6, 0, 5, 0, 8'h05}, '{3'b010, 4'd9, 0, 7, 2, 8'h13},
      '{3'b010, 4'd10, 0, 7, 2, 8'h31}, '{3'b010, 4'd9, 0, 7, 0, 8'h7F},
      '{3'b111, 4'd6, 2, 7, 7, 8'h00}, '{3'b010, 4'd6, 0, 2, 0, 8'h02},
      '{3'b011, 4'd9, 3, 7, 2, 8'h13}, '{3'b011, 4'd6, 5, 3, 3, 8'h06},
      '{3'b010, 4'd6, 0, 5, 0, 8'h06}, '{3'b011, 4'd10, 0, 7, 2, 8'h31},
      '{3'b011, 4'd6, 0, 0, 0, 8'h02}
    };
    for (int i = 0; i < 8; i++) mreg[i] = i;
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_rst", 16'(in_ready), 16'd0);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_result", 16'(out_result), 16'd0);
    check("rst_out_zero", 16'(out_zero), 16'd0);
    check("rst_out_wr", 16'(out_wr), 16'd0);
    check("ready_after_rst", 16'(in_ready), 16'd1);
    for (int i = 0; i < NT; i++) issue(tbl[i].op, tbl[i].f, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, 1, tbl[i].eres);
    repeat (8) @(negedge clk);
    latency(4'd6, 2, 0);
    latency(4'd9, 6, 4);
    latency(4'd10, 6, 4);
    issue(3'b011, 4'd9, 0, 7, 2, 2, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("ready_abort_rst", 16'(in_ready), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = i;
    begin
      int seen = 0;
      repeat (12) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("abort_no_out_valid", 16'(seen), 16'd0);
    end
    check("abort_out_result", 16'(out_result), 16'd0);
    check("abort_ready", 16'(in_ready), 16'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) issue(3'b010, 4'd6, 0, i, 0, 0, 8'd0);
    for (int k = 0; k < 400; k++) begin
      logic [2:0] op;
      op = $urandom_range(0, 1) ? 3'b011 : 3'b010;
      if ($urandom_range(0, 9) == 0) begin
        op = 3'($urandom_range(0, 7));
        if (op[2:1] == 2'b01) op = op ^ 3'b100;
      end
      issue(op, 4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), 0, 8'd0);
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (12) @(negedge clk);
    check("drained", 16'(expq.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_pipe_core.md
# alu_pipe_core

Parametrised two-stage execute core: successor to the fixed 4-bit, 8-register ALU/register-file processor, generalised in data width and register count. Accepts one packed instruction per cycle on a valid/ready handshake, reads two registers (with write-back forwarding), executes in a registered ALU stage, and writes the low word back. DIV/MOD use an iterative divider that back-pressures the input. Sits between the pin-level instruction assembler and the result/flag output pins.

## Interface

- DATA_W, 4, register and operand width (≥2)
- NREGS, 8, register count (power of two, ≥2); RA_W = clog2(NREGS)
- INST_W, 7+3*RA_W, derived instruction width (not overridable)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  core can accept this cycle
- in_inst  in  INST_W  [2:0] op, [6:3] func, then rs2, rs1, rd (RA_W each, rd in MSBs)
- out_valid  out  1  one-cycle pulse: result registered
- out_result  out  2*DATA_W  full ALU result
- out_zero  out  1  out_result == 0
- out_wr  out  1  this result was written to rd

## Operation

- Reset: reg[i] = i mod 2^DATA_W; out_valid=0, out_result=0, out_zero=0, out_wr=0, in_ready=0 while rst high; pipeline and divider cleared.
- op 3'b011: execute and write result[DATA_W-1:0] to rd. op 3'b010: execute, no write. Other op: consumed, no output, no write.
- func (unsigned operands a=reg[rs1], b=reg[rs2], results zero-extended to 2*DATA_W):
  - 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR (DATA_W-bit)
  - 6 ADD {carry,sum}; 7 SUB {borrow,a-b mod 2^DATA_W}
  - 8 MUL full 2*DATA_W product
  - 9 DIV {rem,quot}, writes quot; 10 MOD {quot,rem}, writes rem; b==0: quot=all ones, rem=a
  - 11 LT, 12 GT, 13 EQ: 1 or 0
  - 14 SHL a<<b, 15 SHR a>>b, DATA_W-bit; b ≥ DATA_W gives 0
- Stage 1 (operand regs): loaded at accept edge. Read mux forwards stage-2 write data when stage 2 writes rd equal to rs1/rs2 at the same edge.
- Stage 2 (execute): result register, out_* and register write updated together.
- Divider: restoring, one quotient bit per cycle, DATA_W iterations; b==0 takes the same latency.
- Writes to any register, including reg[0], are allowed.

## Timing

- Accept at edge E0 when in_valid && in_ready.
- Single-cycle funcs: result, flags, writeback at E1; out_valid high the cycle after E1. Throughput one per cycle.
- DIV/MOD: result and writeback at E0+DATA_W+1. in_ready=0 in the cycles closing at E1..E0+DATA_W; high again in the cycle closing at E0+DATA_W+1, so a dependent instruction can be accepted at that edge and receives the forwarded value.
- in_ready is also low during rst; otherwise high.
- Back-to-back RAW hazard (rd of instr N = rs of N+1): no stall; forwarded.
- rst mid-divide: abort, no writeback, no out_valid; registers reinitialised the same edge.
- Non-op (op not 010/011): out_valid stays 0; still occupies one accept slot.

## Test plan

(DATA_W=4, NREGS=8, post-reset values reg[i]=i)
- ADD r1=r7+r7, op 011 -> out_result 0x0E, out_zero 0, out_wr 1; r1 reads 0xE afterwards.
- SUB r3=r2-r5 then next cycle ADD r4=r3+r3 -> 0x1D then 0x1A (forwarded 0xD+0xD); r4=0xA.
- MUL r7*r6 op 011 -> 0x2A, rd=0xA; EQ r5,r5 op 010 -> 0x01, out_wr 0, rd unchanged.
- DIV r7/r2 -> 0x13 at E0+5; MOD r7/r2 -> 0x31; DIV r7/r0 -> 0x7F; in_ready low exactly 4 cycles each.
- Shifts: SHL r1<<r2 -> 0x04; SHR r7>>r5 -> 0x00, out_zero 1.
- rst asserted 2 cycles into DIV -> no out_valid, all regs back to i, in_ready high after release.
